// File: rtl/fc_mac_accum_param_2_pkg.sv
// Shared constants for the FC MAC/accumulate stage. These mirror the
// values used by the FC dual-port address generator so both blocks agree on
// layer geometry and fixed-point format.
package fc_mac_accum_param_2_pkg;

  localparam int FC_INNEURON   = 256;
  localparam int FC_PI         = 1;
  localparam int FC_PO         = 4;
  localparam int FC_OUTNEURON  = 64;
  localparam int FC_DATA_WIDTH = 16;
  localparam int FC_FRAC_BITS  = 8;
  localparam int FC_ACC_WIDTH  = 40;

  // Counter width that stays at least one bit wide for degenerate counts.
  function automatic int cnt_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One output lane of the FC MAC stage: two multiplies (S1), pair sum (S2),
// accumulate with load-on-first (S3), then bias/rescale/saturate/ReLU into
// a registered lane output.
module fc_mac_lane
  import fc_mac_accum_param_2_pkg::*;
#(
  parameter int DATA_WIDTH = FC_DATA_WIDTH,
  parameter int FRAC_BITS  = FC_FRAC_BITS,
  parameter int ACC_WIDTH  = FC_ACC_WIDTH,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         s1_en,
  input  logic                         s2_en,
  input  logic                         s3_en,
  input  logic                         first_s2,
  input  logic                         out_en,
  input  logic signed [DATA_WIDTH-1:0] din_even,
  input  logic signed [DATA_WIDTH-1:0] din_odd,
  input  logic signed [DATA_WIDTH-1:0] w_even,
  input  logic signed [DATA_WIDTH-1:0] w_odd,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic        [DATA_WIDTH-1:0] lane_out
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [PW-1:0]         p_even_r, p_odd_r;
  logic signed [ACC_WIDTH-1:0]  s_r, acc_r;
  logic signed [DATA_WIDTH-1:0] bias1_r, bias2_r, bias3_r;
  logic signed [RW-1:0]         bias_ext_s, sum_s, shr_s;
  logic        [DATA_WIDTH-1:0] sat_s, res_s, lane_out_r;

  // S1: full-width signed products; bias rides along with the beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_even_r <= '0;
      p_odd_r  <= '0;
      bias1_r  <= '0;
    end else if (s1_en) begin
      p_even_r <= PW'(din_even) * PW'(w_even);
      p_odd_r  <= PW'(din_odd) * PW'(w_odd);
      bias1_r  <= bias;
    end
  end

  // S2: pair sum, sign-extended to accumulator width
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_r     <= '0;
      bias2_r <= '0;
    end else if (s2_en) begin
      s_r     <= ACC_WIDTH'(p_even_r) + ACC_WIDTH'(p_odd_r);
      bias2_r <= bias1_r;
    end
  end

  // S3: accumulate; the first beat of a group overwrites instead of adding
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r   <= '0;
      bias3_r <= '0;
    end else if (clear) begin
      acc_r   <= '0;
    end else if (s3_en) begin
      acc_r   <= first_s2 ? s_r : (acc_r + s_r);
      bias3_r <= bias2_r;
    end
  end

  // Bias add, arithmetic rescale, saturate to the output word, optional ReLU
  always_comb begin
    bias_ext_s = RW'(bias3_r) <<< FRAC_BITS;
    sum_s      = RW'(acc_r) + bias_ext_s;
    shr_s      = sum_s >>> FRAC_BITS;
    if (shr_s > SAT_MAX) begin
      sat_s = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (shr_s < SAT_MIN) begin
      sat_s = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      sat_s = shr_s[DATA_WIDTH-1:0];
    end
    if (RELU_EN && sat_s[DATA_WIDTH-1]) begin
      res_s = '0;
    end else begin
      res_s = sat_s;
    end
  end

  // Output register: loads on a result, otherwise holds the last result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_out_r <= '0;
    end else if (out_en) begin
      lane_out_r <= res_s;
    end else begin
      lane_out_r <= lane_out_r;
    end
  end

  assign lane_out = lane_out_r;

endmodule

// File: rtl/fc_mac_accum_param_2.sv
// FC MAC/accumulate stage top: beat and group counters, the valid/tag
// pipeline that travels alongside the lane data, and PO lane instances.
module fc_mac_accum_param_2
  import fc_mac_accum_param_2_pkg::*;
#(
  parameter int DATA_WIDTH = FC_DATA_WIDTH,
  parameter int FRAC_BITS  = FC_FRAC_BITS,
  parameter int ACC_WIDTH  = FC_ACC_WIDTH,
  parameter int INNEURON   = FC_INNEURON,
  parameter int PI         = FC_PI,
  parameter int PO         = FC_PO,
  parameter int OUTNEURON  = FC_OUTNEURON,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      dina,
  input  logic [DATA_WIDTH-1:0]      dinb,
  input  logic [2*PO*DATA_WIDTH-1:0] wts,
  input  logic [PO*DATA_WIDTH-1:0]   bias,
  output logic                       out_valid,
  output logic [PO*DATA_WIDTH-1:0]   out_data,
  output logic                       out_last
);

  localparam int BEATS  = INNEURON / (2 * PI);
  localparam int GROUPS = OUTNEURON / PO;
  localparam int BEAT_W = cnt_width(BEATS);
  localparam int GRP_W  = cnt_width(GROUPS);

  logic [BEAT_W-1:0] beat_cnt_r;
  logic [GRP_W-1:0]  grp_cnt_r;
  logic v1_r, v2_r, v3_r;
  logic first1_r, first2_r, last1_r, last2_r, last3_r;
  logic out_valid_r, out_last_r;
  logic first_s, last_beat_s, take_s, fire_s;

  assign first_s     = (beat_cnt_r == '0);
  assign last_beat_s = (beat_cnt_r == BEAT_W'(BEATS-1));
  assign take_s      = in_valid & ~clear;
  assign fire_s      = v3_r & last3_r & ~clear;

  // Beat counter: advances per accepted beat, wraps after the last beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt_r <= '0;
    end else if (clear) begin
      beat_cnt_r <= '0;
    end else if (take_s) begin
      beat_cnt_r <= last_beat_s ? '0 : (beat_cnt_r + BEAT_W'(1));
    end
  end

  // Valid/tag pipeline; tags only move with valid tokens so bubbles hold them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_r <= 1'b0; v2_r <= 1'b0; v3_r <= 1'b0;
      first1_r <= 1'b0; first2_r <= 1'b0;
      last1_r  <= 1'b0; last2_r  <= 1'b0; last3_r <= 1'b0;
    end else if (clear) begin
      v1_r <= 1'b0; v2_r <= 1'b0; v3_r <= 1'b0;
    end else begin
      v1_r <= in_valid;
      v2_r <= v1_r;
      v3_r <= v2_r;
      if (in_valid) begin
        first1_r <= first_s;
        last1_r  <= last_beat_s;
      end
      if (v1_r) begin
        first2_r <= first1_r;
        last2_r  <= last1_r;
      end
      if (v2_r) begin
        last3_r <= last2_r;
      end
    end
  end

  // Result strobe, final-group flag and group counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      grp_cnt_r   <= '0;
    end else if (clear) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      grp_cnt_r   <= '0;
    end else begin
      out_valid_r <= fire_s;
      out_last_r  <= fire_s && (grp_cnt_r == GRP_W'(GROUPS-1));
      if (fire_s) begin
        grp_cnt_r <= (grp_cnt_r == GRP_W'(GROUPS-1)) ? '0 : (grp_cnt_r + GRP_W'(1));
      end
    end
  end

  for (genvar k = 0; k < PO; k++) begin : g_lane
    fc_mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .ACC_WIDTH  (ACC_WIDTH),
      .RELU_EN    (RELU_EN)
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .s1_en    (take_s),
      .s2_en    (v1_r),
      .s3_en    (v2_r),
      .first_s2 (first2_r),
      .out_en   (fire_s),
      .din_even (dina),
      .din_odd  (dinb),
      .w_even   (wts[(2*k)*DATA_WIDTH +: DATA_WIDTH]),
      .w_odd    (wts[(2*k+1)*DATA_WIDTH +: DATA_WIDTH]),
      .bias     (bias[k*DATA_WIDTH +: DATA_WIDTH]),
      .lane_out (out_data[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_fc_mac_accum_param_2.sv
// Scoreboard bench for fc_mac_accum_param_2. Two instances share stimulus:
// one with ReLU enabled, one without. Expected results are queued as beats
// are issued; a monitor pops and compares whenever out_valid rises.
module tb_fc_mac_accum_param_2;

  localparam int DW     = 16;
  localparam int BEATS  = 4;   // INNEURON=8, PI=1
  localparam int GROUPS = 4;   // OUTNEURON=16, PO=4

  typedef struct {
    logic [63:0] d1;
    logic [63:0] d0;
    bit          last;
    int          cyc;
  } exp_t;

  logic         clk, reset_n, clear, in_valid;
  logic [15:0]  dina, dinb;
  logic [127:0] wts;
  logic [63:0]  bias;
  logic         ov1, ol1, ov0, ol0;
  logic [63:0]  od1, od0;

  exp_t   sbq[$];
  longint macc[4];
  int     mbeat, mgrp;
  int     cyc;
  int     checks, errors;

  fc_mac_accum_param_2 #(.DATA_WIDTH(16), .FRAC_BITS(8), .ACC_WIDTH(40), .INNEURON(8),
    .PI(1), .PO(4), .OUTNEURON(16), .RELU_EN(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .dina(dina),
    .dinb(dinb), .wts(wts), .bias(bias), .out_valid(ov1), .out_data(od1), .out_last(ol1));

  fc_mac_accum_param_2 #(.DATA_WIDTH(16), .FRAC_BITS(8), .ACC_WIDTH(40), .INNEURON(8),
    .PI(1), .PO(4), .OUTNEURON(16), .RELU_EN(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .dina(dina),
    .dinb(dinb), .wts(wts), .bias(bias), .out_valid(ov0), .out_data(od0), .out_last(ol0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model_lane(input longint acc, input logic [15:0] b, input bit relu);
    longint r;
    r = (acc + (longint'($signed(b)) <<< 8)) >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return r[15:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) macc[k] = 0;
    mbeat = 0;
    mgrp  = 0;
  endtask

  // One beat; on the last beat of a group the expected result is queued.
  task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic [127:0] w,
                      input logic [63:0] bs, input bit expect_out);
    exp_t e;
    in_valid = 1'b1; dina = a; dinb = b; wts = w; bias = bs;
    for (int k = 0; k < 4; k++) begin
      macc[k] += longint'($signed(a)) * longint'($signed(w[32*k +: 16]))
               + longint'($signed(b)) * longint'($signed(w[32*k+16 +: 16]));
    end
    if (mbeat == BEATS-1) begin
      for (int k = 0; k < 4; k++) begin
        e.d1[16*k +: 16] = model_lane(macc[k], bs[16*k +: 16], 1'b1);
        e.d0[16*k +: 16] = model_lane(macc[k], bs[16*k +: 16], 1'b0);
        macc[k] = 0;
      end
      e.last = (mgrp == GROUPS-1);
      e.cyc  = cyc + 4;
      if (expect_out) begin
        sbq.push_back(e);
        mgrp = (mgrp + 1) % GROUPS;
      end
      mbeat = 0;
    end else begin
      mbeat++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    dina = 16'($urandom); dinb = 16'($urandom);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic group(input logic [15:0] a, input logic [15:0] b, input logic [127:0] w,
                       input logic [63:0] bs, input int gaps, input bit expect_out);
    for (int i = 0; i < BEATS; i++) begin
      beat(a, b, w, bs, expect_out);
      if (gaps > 0 && i < BEATS-1) idle(gaps);
    end
    in_valid = 1'b0;
  endtask

  // clear asserted together with a random beat that must be dropped
  task automatic do_clear();
    clear = 1'b1; in_valid = 1'b1;
    dina = 16'($urandom); dinb = 16'($urandom);
    wts = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    model_reset();
  endtask

  // Monitor: every result pulse must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && (ov1 || ov0)) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: got out_valid %b/%b data %h expected no output (cycle %0d)",
                 ov1, ov0, od1, cyc);
      end else begin
        e = sbq.pop_front();
        chk("valid_relu", {63'd0, ov1}, 64'd1);
        chk("valid_norelu", {63'd0, ov0}, 64'd1);
        chk("data_relu", od1, e.d1);
        chk("data_norelu", od0, e.d0);
        chk("last_relu", {63'd0, ol1}, {63'd0, e.last});
        chk("last_norelu", {63'd0, ol0}, {63'd0, e.last});
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    logic [127:0] w_unit, w_max, w_neg, w_mix;
    checks = 0; errors = 0; cyc = 0;
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    dina = '0; dinb = '0; wts = '0; bias = '0;
    model_reset();
    w_unit = {8{16'h0100}};
    w_max  = {8{16'h7FFF}};
    w_neg  = {8{16'h8000}};
    w_mix  = {16'h0000, 16'h0001, 16'h0040, 16'h0080, 16'hFF00, 16'hFE00, 16'h0200, 16'h0100};

    // Reset with random inputs: outputs stay zero
    repeat (4) begin
      in_valid = 1'($urandom); dina = 16'($urandom); dinb = 16'($urandom);
      wts = {$urandom, $urandom, $urandom, $urandom}; bias = {$urandom, $urandom};
      @(negedge clk);
      chk("reset_valid", {62'd0, ov1, ov0}, 64'd0);
      chk("reset_data_relu", od1, 64'd0);
      chk("reset_data_norelu", od0, 64'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; bias = '0;
    reset_n = 1'b1;

    // Fewer than BEATS beats: nothing may come out
    for (int i = 0; i < BEATS-1; i++) beat(16'h0100, 16'h0100, w_unit, 64'd0, 1'b1);
    idle(8);
    do_clear();
    idle(2);

    // Unit dot product: 4 beats * 2 * 1.0 = 8.0 -> 0x0800 per lane
    group(16'h0100, 16'h0100, w_unit, 64'd0, 0, 1'b1);
    idle(6);
    // Same with bubbles between beats
    group(16'h0100, 16'h0100, w_unit, 64'd0, 1, 1'b1);
    idle(6);
    // Positive saturation
    group(16'h7FFF, 16'h7FFF, w_max, {4{16'h7FFF}}, 0, 1'b1);
    idle(6);
    // Negative saturation: ReLU instance clamps to 0, other saturates to 0x8000
    group(16'h7FFF, 16'h7FFF, w_neg, 64'd0, 0, 1'b1);
    idle(6);
    // Mixed signs, fractions and biases per lane (grp wraps here)
    group(16'h0200, 16'h0180, w_mix, {16'hFFF0, 16'h0003, 16'h0010, 16'hFFFF}, 2, 1'b1);
    idle(6);

    // Back-to-back groups from a fresh group count, one past a full wrap
    do_clear();
    for (int g = 0; g < GROUPS+1; g++) begin
      group(16'((g+1) << 6), 16'(16'hFF80 + g), w_mix,
            {16'(4*g+3), 16'(4*g+2), 16'(4*g+1), 16'(4*g)}, 0, 1'b1);
    end
    idle(6);

    // clear mid-group discards the partial sum
    do_clear();
    beat(16'h0100, 16'h0100, w_max, 64'd0, 1'b1);
    beat(16'h0100, 16'h0100, w_max, 64'd0, 1'b1);
    do_clear();
    group(16'h0100, 16'h0100, w_unit, 64'd0, 0, 1'b1);
    idle(6);

    // clear while a result is in flight suppresses it
    group(16'h0300, 16'h0100, w_unit, 64'd0, 0, 1'b0);
    idle(2);
    do_clear();
    idle(4);
    group(16'h0080, 16'h0100, w_mix, {4{16'h0005}}, 0, 1'b1);
    idle(6);

    // Asynchronous reset mid-group discards the partial sum
    beat(16'h0100, 16'h0100, w_max, 64'd0, 1'b1);
    beat(16'h0100, 16'h0100, w_max, 64'd0, 1'b1);
    #2 reset_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midreset_valid", {62'd0, ov1, ov0}, 64'd0);
    chk("midreset_data", od1, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    group(16'hFF00, 16'h0100, w_unit, {4{16'h0002}}, 0, 1'b1);
    idle(6);

    // Drain: any result still owed is a failure
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    if (sbq.size() != 0) begin
      $display("FAIL missing_out: got %0d results outstanding expected 0", sbq.size());
      errors += sbq.size();
      checks += sbq.size();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
